// File: rtl/vram_write_arbiter.sv
// VIDEORAM write arbiter: two round-robin requesters plus a whole-RAM fill
// engine that takes priority over both. All RAM write outputs are registered.
module vram_write_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FILL_START,
  input  logic [DATA_W-1:0] FILL_VALUE,
  output logic              FILL_BUSY,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_GNT,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_GNT,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WEN
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] fill_val, fill_val_nx;
  logic              last_b, last_b_nx;   // 1: B was served most recently
  logic [ADDR_W-1:0] waddr_nx;
  logic [DATA_W-1:0] wdata_nx;
  logic              wen_nx;

  assign FILL_BUSY = (state == FILL);

  // Next-state, fill sequencing, round-robin grant and next RAM write
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    fill_val_nx = fill_val;
    last_b_nx   = last_b;
    waddr_nx    = RAM_WADDR;
    wdata_nx    = RAM_WDATA;
    wen_nx      = 1'b0;
    A_GNT       = 1'b0;
    B_GNT       = 1'b0;
    unique case (state)
      IDLE: begin
        if (FILL_START) begin
          state_nx    = FILL;
          cnt_nx      = '0;
          fill_val_nx = FILL_VALUE;
        end else if (!RST) begin
          // Contested grant goes to whoever was not served last
          A_GNT = A_REQ & (~B_REQ | last_b);
          B_GNT = B_REQ & (~A_REQ | ~last_b);
          if (A_GNT) begin
            wen_nx    = 1'b1;
            waddr_nx  = A_ADDR;
            wdata_nx  = A_DATA;
            last_b_nx = 1'b0;
          end else if (B_GNT) begin
            wen_nx    = 1'b1;
            waddr_nx  = B_ADDR;
            wdata_nx  = B_DATA;
            last_b_nx = 1'b1;
          end
        end
      end
      FILL: begin
        wen_nx   = 1'b1;
        waddr_nx = cnt;
        wdata_nx = fill_val;
        // Counter parks on the last address instead of wrapping
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, fill counter, round-robin pointer and RAM write registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      fill_val  <= '0;
      last_b    <= 1'b1;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
      RAM_WEN   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      fill_val  <= fill_val_nx;
      last_b    <= last_b_nx;
      RAM_WADDR <= waddr_nx;
      RAM_WDATA <= wdata_nx;
      RAM_WEN   <= wen_nx;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: stimulus pushes expected RAM writes
// (address, data, cycle), a monitor pops and compares on every RAM_WEN.
module tb_vram_write_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FILL_START;
  logic [5:0] FILL_VALUE;
  logic       FILL_BUSY;
  logic       A_REQ, B_REQ, A_GNT, B_GNT;
  logic [3:0] A_ADDR, B_ADDR, RAM_WADDR;
  logic [5:0] A_DATA, B_DATA, RAM_WDATA;
  logic       RAM_WEN;

  typedef struct {
    logic [3:0] addr;
    logic [5:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  vram_write_arbiter #(.ADDR_W(4), .DATA_W(6)) dut (
    .CLK(CLK), .RST(RST), .FILL_START(FILL_START), .FILL_VALUE(FILL_VALUE),
    .FILL_BUSY(FILL_BUSY),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_GNT(A_GNT),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_GNT(B_GNT),
    .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA), .RAM_WEN(RAM_WEN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write
  always @(negedge CLK) begin
    if (RAM_WEN === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                 RAM_WADDR, RAM_WDATA, cyc_n);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", RAM_WADDR, e.addr);
        chk("wr_data", RAM_WDATA, e.data);
        chk("wr_cycle", cyc_n, e.cyc);
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [5:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_gnt(input string nm, input logic ea, input logic eb);
    @(negedge CLK);
    chk({nm, "_a_gnt"}, A_GNT, ea);
    chk({nm, "_b_gnt"}, B_GNT, eb);
  endtask

  task automatic idle_inputs();
    FILL_START = 1'b0;
    A_REQ = 1'b0;
    B_REQ = 1'b0;
  endtask

  // Reset with requests and FILL_START asserted: no grants, no fill afterwards
  task automatic do_reset();
    RST = 1'b1;
    A_REQ = 1'b1;
    B_REQ = 1'b1;
    FILL_START = 1'b1;
    chk_gnt("rst0", 1'b0, 1'b0);
    step();
    chk_gnt("rst1", 1'b0, 1'b0);
    chk("rst_busy", FILL_BUSY, 1'b0);
    chk("rst_wen", RAM_WEN, 1'b0);
    step();
    RST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    chk("post_rst_busy", FILL_BUSY, 1'b0);
    chk("post_rst_wen", RAM_WEN, 1'b0);
    chk("post_rst_waddr", RAM_WADDR, 4'h0);
    chk("post_rst_wdata", RAM_WDATA, 6'h00);
    step();
  endtask

  initial begin
    int c;
    logic [3:0] ca [4];
    logic [3:0] cb [4];
    logic       cga[4];

    RST = 1'b1;
    FILL_VALUE = 6'h3F;
    A_ADDR = 4'h0; A_DATA = 6'h00;
    B_ADDR = 4'h0; B_DATA = 6'h00;
    idle_inputs();
    do_reset();

    // Single A request
    A_REQ = 1'b1; A_ADDR = 4'd5; A_DATA = 6'h2A;
    chk_gnt("single_a", 1'b1, 1'b0);
    push(4'd5, 6'h2A, cyc_n + 1);
    step();
    A_REQ = 1'b0;
    chk_gnt("single_a_done", 1'b0, 1'b0);
    step();
    @(negedge CLK);
    chk("single_a_wen_low", RAM_WEN, 1'b0);
    chk("single_a_addr_hold", RAM_WADDR, 4'd5);
    chk("single_a_data_hold", RAM_WDATA, 6'h2A);
    step();

    // Contention after reset: A,B,A,B
    do_reset();
    ca = '{4'd1, 4'd2, 4'd2, 4'd3};
    cb = '{4'd9, 4'd9, 4'd10, 4'd10};
    cga = '{1'b1, 1'b0, 1'b1, 1'b0};
    A_REQ = 1'b1;
    B_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A_ADDR = ca[i]; A_DATA = {2'b01, ca[i]};
      B_ADDR = cb[i]; B_DATA = {2'b10, cb[i]};
      chk_gnt("contend", cga[i], ~cga[i]);
      if (cga[i]) push(ca[i], {2'b01, ca[i]}, cyc_n + 1);
      else        push(cb[i], {2'b10, cb[i]}, cyc_n + 1);
      step();
    end
    idle_inputs();

    // B alone holds REQ: granted every cycle
    for (int i = 0; i < 3; i++) begin
      B_REQ = 1'b1; B_ADDR = 4'd12 + 4'(i); B_DATA = 6'(i + 1);
      chk_gnt("b_stream", 1'b0, 1'b1);
      push(4'd12 + 4'(i), 6'(i + 1), cyc_n + 1);
      step();
    end
    idle_inputs();
    step();

    // Fill with A requesting in the same cycle and held throughout
    FILL_VALUE = 6'h15; FILL_START = 1'b1;
    A_REQ = 1'b1; A_ADDR = 4'd3; A_DATA = 6'h07;
    c = cyc_n;
    chk_gnt("fill_start", 1'b0, 1'b0);
    chk("fill_start_busy", FILL_BUSY, 1'b0);
    for (int i = 0; i < 16; i++) push(4'(i), 6'h15, c + 2 + i);
    step();
    for (int k = 1; k <= 16; k++) begin
      FILL_START = (k == 5);
      if (k == 5) FILL_VALUE = 6'h3F;
      chk_gnt("fill_run", 1'b0, 1'b0);
      chk("fill_busy", FILL_BUSY, 1'b1);
      step();
    end
    FILL_START = 1'b0;
    chk_gnt("after_fill", 1'b1, 1'b0);
    chk("after_fill_busy", FILL_BUSY, 1'b0);
    push(4'd3, 6'h07, cyc_n + 1);
    step();
    idle_inputs();
    step();
    step();

    // Reset after the 7th fill write aborts the fill
    FILL_VALUE = 6'h0A; FILL_START = 1'b1;
    c = cyc_n;
    chk_gnt("fill2_start", 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) push(4'(i), 6'h0A, c + 2 + i);
    step();
    FILL_START = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      chk("fill2_busy", FILL_BUSY, 1'b1);
      step();
    end
    do_reset();

    // First contested grant after reset goes to A
    A_REQ = 1'b1; A_ADDR = 4'd1; A_DATA = 6'h11;
    B_REQ = 1'b1; B_ADDR = 4'd2; B_DATA = 6'h22;
    chk_gnt("post_abort_a", 1'b1, 1'b0);
    push(4'd1, 6'h11, cyc_n + 1);
    step();
    A_REQ = 1'b0;
    chk_gnt("post_abort_b", 1'b0, 1'b1);
    push(4'd2, 6'h22, cyc_n + 1);
    step();
    idle_inputs();
    step();
    step();

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
